// File: rtl/piso_frame_tx.sv
// -----------------------------------------------------------------------------
// piso_frame_tx
//   Parallel-in serial-out framed transmitter. A WIDTH-bit word is accepted
//   over a valid/ready handshake and sent on a single line as:
//     start bit (0), WIDTH data bits LSB first, stop bit (1).
//   Every bit is held on sout for BIT_CYCLES clocks.
//
// Parameters
//   WIDTH       data bits per frame (>=1)
//   BIT_CYCLES  clocks each bit is held on sout (>=1)
//
// Ports
//   clk         single clock, all state changes on posedge
//   reset       synchronous, active-low reset
//   din         parallel word, captured on the handshake edge
//   load_valid  producer has a word on din
//   load_ready  block can accept a word (high only while idle)
//   sout        serial line, idles high (registered)
//   busy        frame in progress (registered)
//   done        one-cycle pulse in the first idle cycle after a stop bit
// -----------------------------------------------------------------------------
module piso_frame_tx #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam int IW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shreg_reg, shreg_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [IW-1:0]    idx_reg, idx_next;
    logic             sout_reg, sout_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    logic [WIDTH-1:0] shift_val;
    logic             period_end;

    // Right-shift chain of the data register: each flop takes its upper
    // neighbour, the MSB fills with zero.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_msb
                assign shift_val[gi] = 1'b0;
            end else begin : g_mid
                assign shift_val[gi] = shreg_reg[gi + 1];
            end
        end
    endgenerate

    assign period_end = (cnt_reg == CW'(BIT_CYCLES - 1));
    assign load_ready = (state_reg == ST_IDLE);

    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        done_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (load_valid) begin
                    shreg_next = din;
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (period_end) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = ST_DATA;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_DATA: begin
                if (period_end) begin
                    cnt_next = '0;
                    if (idx_reg == IW'(WIDTH - 1)) begin
                        state_next = ST_STOP;
                    end else begin
                        shreg_next = shift_val;
                        idx_next   = idx_reg + IW'(1);
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_STOP: begin
                if (period_end) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Outputs are computed from the next state so the registered line
        // changes on the very edge that enters a state (start bit begins on
        // the handshake edge, leaving a single idle-high cycle between frames).
        case (state_next)
            ST_START: sout_next = 1'b0;
            ST_DATA:  sout_next = shreg_next[0];
            default:  sout_next = 1'b1;
        endcase
        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            shreg_reg <= '0;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            sout_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            sout_reg  <= sout_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign sout = sout_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_piso_frame_tx.sv
module tb_piso_frame_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       load_valid;
    logic       load_ready, sout, busy, done;

    logic [7:0] din1;
    logic       load_valid1;
    logic       load_ready1, sout1, busy1, done1;

    int checks = 0;
    int passes = 0;

    always #10 clk = ~clk;

    piso_frame_tx #(.WIDTH(8), .BIT_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .sout       (sout),
        .busy       (busy),
        .done       (done)
    );

    piso_frame_tx #(.WIDTH(8), .BIT_CYCLES(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .din        (din1),
        .load_valid (load_valid1),
        .load_ready (load_ready1),
        .sout       (sout1),
        .busy       (busy1),
        .done       (done1)
    );

    // Called at the first negedge after the handshake edge. Checks all
    // 40 frame cycles and the done cycle, returning at the done-cycle negedge.
    task automatic check_frame(input logic [7:0] data, input string name);
        logic [9:0] fr;
        fr = {1'b1, data, 1'b0};
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (sout !== fr[k/4] || busy !== 1'b1 || done !== 1'b0 || load_ready !== 1'b0)
                $display("FAIL %s cyc %0d: sout=%b busy=%b done=%b ready=%b, expected sout=%b busy=1 done=0 ready=0",
                         name, k, sout, busy, done, load_ready, fr[k/4]);
            else
                passes++;
            @(negedge clk);
        end
        checks++;
        if (sout !== 1'b1 || busy !== 1'b0 || done !== 1'b1 || load_ready !== 1'b1)
            $display("FAIL %s done_cycle: sout=%b busy=%b done=%b ready=%b, expected 1 0 1 1",
                     name, sout, busy, done, load_ready);
        else
            passes++;
    endtask

    task automatic test_reset();
        // reset and load_valid asserted together: reset must win
        reset = 1'b0; load_valid = 1'b1; din = 8'h55;
        load_valid1 = 1'b1; din1 = 8'h55;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sout !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_hold: sout=%b busy=%b done=%b, expected 1 0 0", sout, busy, done);
        else
            passes++;
        reset = 1'b1; load_valid = 1'b0; load_valid1 = 1'b0;
        @(negedge clk);
        checks++;
        if (sout !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1)
            $display("FAIL reset_release: sout=%b busy=%b done=%b ready=%b, expected 1 0 0 1",
                     sout, busy, done, load_ready);
        else
            passes++;
        checks++;
        if (busy1 !== 1'b0 || sout1 !== 1'b1 || load_ready1 !== 1'b1)
            $display("FAIL reset_dut1: sout=%b busy=%b ready=%b, expected 1 0 1", sout1, busy1, load_ready1);
        else
            passes++;
    endtask

    task automatic test_single_frame();
        din = 8'hA5; load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        check_frame(8'hA5, "frame_a5");
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sout !== 1'b1)
            $display("FAIL a5_after_done: done=%b busy=%b sout=%b, expected 0 0 1", done, busy, sout);
        else
            passes++;
    endtask

    task automatic test_back_to_back();
        din = 8'h3C; load_valid = 1'b1;
        @(negedge clk);
        din = 8'hC3;                 // load_valid stays high
        check_frame(8'h3C, "b2b_first");
        @(negedge clk);              // handshake happened at the end of the done cycle
        load_valid = 1'b0;
        check_frame(8'hC3, "b2b_second");
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL b2b_end: done=%b busy=%b, expected 0 0", done, busy);
        else
            passes++;
    endtask

    task automatic test_din_ignored();
        din = 8'hFF; load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        fork
            check_frame(8'hFF, "din_ignored");
            begin
                repeat (10) @(negedge clk);
                din = 8'h00; load_valid = 1'b1;
                @(negedge clk);
                load_valid = 1'b0;
            end
        join
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || sout !== 1'b1)
                $display("FAIL no_extra_frame cyc %0d: busy=%b sout=%b, expected 0 1", k, busy, sout);
            else
                passes++;
        end
    endtask

    task automatic test_reset_midframe();
        din = 8'h0F; load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        repeat (14) @(negedge clk);  // inside data bit 2
        checks++;
        if (busy !== 1'b1)
            $display("FAIL midframe_busy: busy=%b, expected 1", busy);
        else
            passes++;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if (sout !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1)
            $display("FAIL midframe_reset: sout=%b busy=%b done=%b ready=%b, expected 1 0 0 1",
                     sout, busy, done, load_ready);
        else
            passes++;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0)
                $display("FAIL midframe_quiet cyc %0d: done=%b busy=%b, expected 0 0", k, done, busy);
            else
                passes++;
        end
        din = 8'h0F; load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        check_frame(8'h0F, "after_reset");
        @(negedge clk);
    endtask

    task automatic test_bit_cycles_one();
        logic [9:0] fr;
        fr = 10'b11_0000_0010;       // {stop, 8'h81, start}
        din1 = 8'h81; load_valid1 = 1'b1;
        @(negedge clk);
        load_valid1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (sout1 !== fr[k] || busy1 !== 1'b1 || done1 !== 1'b0)
                $display("FAIL bc1 cyc %0d: sout=%b busy=%b done=%b, expected sout=%b busy=1 done=0",
                         k, sout1, busy1, done1, fr[k]);
            else
                passes++;
            @(negedge clk);
        end
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || sout1 !== 1'b1)
            $display("FAIL bc1_done: done=%b busy=%b sout=%b, expected 1 0 1", done1, busy1, sout1);
        else
            passes++;
        @(negedge clk);
        checks++;
        if (done1 !== 1'b0)
            $display("FAIL bc1_done_pulse: done=%b, expected 0", done1);
        else
            passes++;
    endtask

    initial begin
        reset = 1'b0; din = '0; load_valid = 1'b0;
        din1 = '0; load_valid1 = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_din_ignored();
        test_reset_midframe();
        test_bit_cycles_one();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
